// File: rtl/fp_pkg.sv
// Shared definitions for the pipelined floating-point multiplier.
//   fp_class_e  : operand / result classification
//   FLAG_*      : bit positions inside the 3-bit flags word {invalid, overflow, underflow}
//   fp_bias     : exponent bias for a given exponent width
//   fp_qnan     : canonical quiet NaN {0, all-ones, 1, zeros}, returned LSB-aligned in 64 bits
//   fp_classify : classify an operand from its exponent / fraction summary bits
package fp_pkg;

    typedef enum logic [1:0] {FP_ZERO, FP_NORM, FP_INF, FP_NAN} fp_class_e;

    localparam int FLAG_UF  = 0;
    localparam int FLAG_OF  = 1;
    localparam int FLAG_INV = 2;
    localparam int FLAG_W   = 3;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        logic [63:0] w;
        w = '0;
        for (int i = 0; i < exp_w; i++) w[man_w + i] = 1'b1;
        w[man_w - 1] = 1'b1;
        return w;
    endfunction

    // Subnormals (exp == 0, frac != 0) are flushed and classify as zero.
    function automatic fp_class_e fp_classify(input logic exp_zero, input logic exp_ones,
                                              input logic frac_zero);
        if (exp_zero) return FP_ZERO;
        if (!exp_ones) return FP_NORM;
        return frac_zero ? FP_INF : FP_NAN;
    endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack for a normalised product.
//   sign_i      : result sign
//   exp_i       : signed biased exponent (EXP_W+2 bits, cannot wrap)
//   man_i       : normalised mantissa including the leading one
//   grs_i       : {guard, round, sticky}
//   word_o      : packed {sign, exp, frac}; saturates to inf / zero on range errors
//   overflow_o  : final exponent >= all-ones
//   underflow_o : final exponent <= 0
module fp_round_pack #(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     sign_i,
    input  logic signed [EXP_W+1:0]  exp_i,
    input  logic [MAN_W:0]           man_i,
    input  logic [2:0]               grs_i,
    output logic [EXP_W+MAN_W:0]     word_o,
    output logic                     overflow_o,
    output logic                     underflow_o
);
    localparam int EW2 = EXP_W + 2;
    localparam logic signed [EW2-1:0] EXP_MAX  = EW2'((1 << EXP_W) - 1);
    localparam logic signed [EW2-1:0] EXP_ZERO = '0;

    logic                  rnd_up;
    logic                  carry;
    logic [MAN_W+1:0]      man_r;
    logic [MAN_W-1:0]      frac;
    logic signed [EW2-1:0] exp_f;

    always_comb begin
        // Round up when above half, or exactly half and the kept LSB is odd.
        rnd_up = grs_i[2] & (grs_i[1] | grs_i[0] | man_i[0]);
        man_r  = {1'b0, man_i} + {{(MAN_W+1){1'b0}}, rnd_up};
        // Carry-out means the mantissa became 10.00..0: renormalise by one.
        carry  = man_r[MAN_W+1];
        frac   = carry ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
        exp_f  = exp_i + $signed({{(EW2-1){1'b0}}, carry});

        overflow_o  = (exp_f >= EXP_MAX);
        underflow_o = (exp_f <= EXP_ZERO);

        if (overflow_o)
            word_o = {sign_i, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        else if (underflow_o)
            word_o = {sign_i, {(EXP_W+MAN_W){1'b0}}};
        else
            word_o = {sign_i, exp_f[EXP_W-1:0], frac};
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined IEEE-style multiplier with valid/ready handshakes.
//   S1: unpack, classify, mantissa multiply, exponent sum
//   S2: normalise, extract guard/round/sticky
//   S3: round, pack, special-case select (registered output)
// Ports:
//   clk_in, rst_n          : clock, async active-low reset
//   a, b, tag_in           : operands {sign, exp, frac} and sideband tag
//   in_valid / in_ready    : operand handshake
//   result, tag_out, flags : product, matching tag, {invalid, overflow, underflow}
//   out_valid / out_ready  : result handshake
// Requires MAN_W >= 3 (guard/round/sticky extraction).
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10,
    parameter int TAG_W = 4
) (
    input  logic                 clk_in,
    input  logic                 rst_n,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    input  logic [TAG_W-1:0]     tag_in,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic [TAG_W-1:0]     tag_out,
    output logic [FLAG_W-1:0]    flags,
    output logic                 out_valid,
    input  logic                 out_ready
);
    localparam int W      = 1 + EXP_W + MAN_W;
    localparam int MW     = MAN_W + 1;
    localparam int PW     = 2 * MW;
    localparam int EW2    = EXP_W + 2;
    localparam int STAGES = 3;
    localparam logic signed [EW2-1:0] BIAS_S = EW2'(fp_bias(EXP_W));
    localparam logic [W-1:0]          QNAN   = W'(fp_qnan(EXP_W, MAN_W));

    // ---------------- pipeline control ----------------
    logic [STAGES:1] vld_pipe_q, vld_pipe_d, stg_en;

    always_comb begin
        // A stage may load when it is empty or its content moves on this cycle.
        stg_en[3] = !vld_pipe_q[3] || out_ready;
        stg_en[2] = !vld_pipe_q[2] || stg_en[3];
        stg_en[1] = !vld_pipe_q[1] || stg_en[2];
        vld_pipe_d[1] = stg_en[1] ? in_valid      : vld_pipe_q[1];
        vld_pipe_d[2] = stg_en[2] ? vld_pipe_q[1] : vld_pipe_q[2];
        vld_pipe_d[3] = stg_en[3] ? vld_pipe_q[2] : vld_pipe_q[3];
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) vld_pipe_q <= '0;
        else        vld_pipe_q <= vld_pipe_d;
    end

    assign in_ready  = stg_en[1];
    assign out_valid = vld_pipe_q[3];

    // ---------------- S1: unpack / classify / multiply ----------------
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_frac, b_frac;
    fp_class_e        a_cls, b_cls;

    fp_class_e             s1_cls_d, s1_cls_q;
    logic                  s1_sign_d, s1_sign_q;
    logic signed [EW2-1:0] s1_exp_d, s1_exp_q;
    logic [PW-1:0]         s1_prod_d, s1_prod_q;
    logic [TAG_W-1:0]      s1_tag_q;

    always_comb begin
        a_exp  = a[W-2:MAN_W];
        b_exp  = b[W-2:MAN_W];
        a_frac = a[MAN_W-1:0];
        b_frac = b[MAN_W-1:0];
        a_cls  = fp_classify(a_exp == '0, &a_exp, a_frac == '0);
        b_cls  = fp_classify(b_exp == '0, &b_exp, b_frac == '0);

        // Precedence: invalid > infinity > zero > normal.
        s1_cls_d = FP_NORM;
        if (a_cls == FP_NAN || b_cls == FP_NAN ||
            (a_cls == FP_INF && b_cls == FP_ZERO) || (a_cls == FP_ZERO && b_cls == FP_INF))
            s1_cls_d = FP_NAN;
        else if (a_cls == FP_INF || b_cls == FP_INF)
            s1_cls_d = FP_INF;
        else if (a_cls == FP_ZERO || b_cls == FP_ZERO)
            s1_cls_d = FP_ZERO;

        s1_sign_d = a[W-1] ^ b[W-1];
        // Two extra bits keep the sum signed and wrap-free through later +1 adjustments.
        s1_exp_d  = $signed({2'b00, a_exp}) + $signed({2'b00, b_exp}) - BIAS_S;
        s1_prod_d = {{MW{1'b0}}, 1'b1, a_frac} * {{MW{1'b0}}, 1'b1, b_frac};
    end

    always_ff @(posedge clk_in) begin
        if (stg_en[1] && in_valid) begin
            s1_cls_q  <= s1_cls_d;
            s1_sign_q <= s1_sign_d;
            s1_exp_q  <= s1_exp_d;
            s1_prod_q <= s1_prod_d;
            s1_tag_q  <= tag_in;
        end
    end

    // ---------------- S2: normalise ----------------
    logic                  norm;
    logic signed [EW2-1:0] s2_exp_d, s2_exp_q;
    logic [MAN_W:0]        s2_man_d, s2_man_q;
    logic [2:0]            s2_grs_d, s2_grs_q;
    fp_class_e             s2_cls_q;
    logic                  s2_sign_q;
    logic [TAG_W-1:0]      s2_tag_q;

    always_comb begin
        // Product of two [1,2) mantissas lies in [1,4); MSB set means [2,4).
        norm = s1_prod_q[PW-1];
        if (norm) begin
            s2_man_d = s1_prod_q[PW-1 -: MW];
            s2_grs_d = {s1_prod_q[MW-1], s1_prod_q[MW-2], |s1_prod_q[MW-3:0]};
        end else begin
            s2_man_d = s1_prod_q[PW-2 -: MW];
            s2_grs_d = {s1_prod_q[MW-2], s1_prod_q[MW-3], |s1_prod_q[MW-4:0]};
        end
        s2_exp_d = s1_exp_q + $signed({{(EW2-1){1'b0}}, norm});
    end

    always_ff @(posedge clk_in) begin
        if (stg_en[2] && vld_pipe_q[1]) begin
            s2_cls_q  <= s1_cls_q;
            s2_sign_q <= s1_sign_q;
            s2_exp_q  <= s2_exp_d;
            s2_man_q  <= s2_man_d;
            s2_grs_q  <= s2_grs_d;
            s2_tag_q  <= s1_tag_q;
        end
    end

    // ---------------- S3: round / pack / select ----------------
    logic [W-1:0]        rp_word;
    logic                rp_of, rp_uf;
    logic [W-1:0]        s3_res_d, s3_res_q;
    logic [FLAG_W-1:0]   s3_flags_d, s3_flags_q;
    logic [TAG_W-1:0]    s3_tag_q;

    fp_round_pack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round_pack (
        .sign_i      (s2_sign_q),
        .exp_i       (s2_exp_q),
        .man_i       (s2_man_q),
        .grs_i       (s2_grs_q),
        .word_o      (rp_word),
        .overflow_o  (rp_of),
        .underflow_o (rp_uf)
    );

    always_comb begin
        s3_res_d   = rp_word;
        s3_flags_d = '0;
        case (s2_cls_q)
            FP_NAN: begin
                s3_res_d             = QNAN;
                s3_flags_d[FLAG_INV] = 1'b1;
            end
            FP_INF:  s3_res_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            FP_ZERO: s3_res_d = {s2_sign_q, {(EXP_W+MAN_W){1'b0}}};
            default: begin
                s3_flags_d[FLAG_OF] = rp_of;
                s3_flags_d[FLAG_UF] = rp_uf;
            end
        endcase
    end

    // Output registers only change when a new result enters, so they hold
    // steady while the consumer stalls.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            s3_res_q   <= '0;
            s3_flags_q <= '0;
            s3_tag_q   <= '0;
        end else if (stg_en[3] && vld_pipe_q[2]) begin
            s3_res_q   <= s3_res_d;
            s3_flags_q <= s3_flags_d;
            s3_tag_q   <= s2_tag_q;
        end
    end

    assign result  = s3_res_q;
    assign flags   = s3_flags_q;
    assign tag_out = s3_tag_q;

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Self-checking bench for fp_mult_pipe at binary16 defaults. Expected results
// are queued when an operation is accepted and compared as results are taken.
module tb_fp_mult_pipe;

    typedef struct packed {
        logic [15:0] res;
        logic [3:0]  tag;
        logic [2:0]  flg;
    } exp_t;

    logic        clk_in = 1'b0;
    logic        rst_n  = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic [3:0]  tag_in = '0;
    logic        in_valid = 1'b0, out_ready = 1'b0;
    logic        in_ready, out_valid;
    logic [15:0] result;
    logic [3:0]  tag_out;
    logic [2:0]  flags;

    always #5 clk_in = ~clk_in;

    fp_mult_pipe dut (
        .clk_in    (clk_in),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .tag_in    (tag_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .result    (result),
        .tag_out   (tag_out),
        .flags     (flags),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    exp_t        sb[$];
    int          n_checks = 0, n_pass = 0, cyc_no = 0;
    logic [15:0] obs_res;
    logic [3:0]  obs_tag;
    logic [2:0]  obs_flg;
    logic        obs_ir, obs_ov;

    // Independent reference: exact integer product, rounded by remainder compare.
    function automatic exp_t model(input logic [15:0] x, input logic [15:0] y, input logic [3:0] t);
        exp_t   r;
        int     ex, ey, fx, fy, e, sh;
        longint p, q, rem, half;
        logic   s, xn, yn, xi, yi, xz, yz;
        ex = int'(x[14:10]); fx = int'(x[9:0]);
        ey = int'(y[14:10]); fy = int'(y[9:0]);
        s  = x[15] ^ y[15];
        xn = (ex == 31) && (fx != 0); yn = (ey == 31) && (fy != 0);
        xi = (ex == 31) && (fx == 0); yi = (ey == 31) && (fy == 0);
        xz = (ex == 0);               yz = (ey == 0);
        r.tag = t;
        r.flg = 3'b000;
        if (xn || yn || (xi && yz) || (yi && xz)) begin
            r.res = 16'h7E00; r.flg = 3'b100;
        end else if (xi || yi) begin
            r.res = {s, 15'h7C00};
        end else if (xz || yz) begin
            r.res = {s, 15'h0000};
        end else begin
            p = longint'(1024 + fx) * longint'(1024 + fy);
            e = ex + ey - 15;
            if (p >= (longint'(1) << 21)) begin sh = 11; e++; end
            else sh = 10;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && (q % 2) == 1)) q = q + 1;
            if (q == 2048) begin q = 1024; e++; end
            if (e >= 31)     begin r.res = {s, 15'h7C00}; r.flg = 3'b010; end
            else if (e <= 0) begin r.res = {s, 15'h0000}; r.flg = 3'b001; end
            else             r.res = {s, e[4:0], q[9:0]};
        end
        return r;
    endfunction

    // One clock: drive inputs, sample at the falling edge, advance past the rising edge.
    task automatic cyc(input logic v, input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] t, input logic ordy,
                       output logic ifire, output logic ofire);
        in_valid = v; a = av; b = bv; tag_in = t; out_ready = ordy;
        @(negedge clk_in);
        ifire   = in_valid && in_ready;
        ofire   = out_valid && out_ready;
        obs_res = result; obs_tag = tag_out; obs_flg = flags;
        obs_ir  = in_ready; obs_ov = out_valid;
        @(posedge clk_in); #1;
        cyc_no++;
    endtask

    task automatic test_reset;
        logic fi, fo;
        rst_n = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        n_checks++;
        if ({out_valid, result, tag_out, flags} !== 24'h0)
            $display("FAIL reset_outputs: got v=%b r=%h t=%h f=%b want all zero", out_valid, result, tag_out, flags);
        else n_pass++;
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        cyc(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, fi, fo);
        n_checks++;
        if (obs_ir !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", obs_ir);
        else n_pass++;
    endtask

    task automatic test_back_to_back;
        logic [15:0] av[2] = '{16'h3C00, 16'h3E00};
        logic [15:0] bv[2] = '{16'h4000, 16'h3E00};
        logic [15:0] rv[2] = '{16'h4000, 16'h4080};
        int   in_at[2], out_at[2];
        int   idx = 0, nout = 0, k;
        logic fi, fo;
        exp_t e;
        for (int i = 0; i < 10; i++) begin
            k = (idx < 2) ? idx : 0;
            cyc(idx < 2, av[k], bv[k], 4'(4'hA + k), 1'b1, fi, fo);
            if (fi) begin
                sb.push_back('{rv[k], 4'(4'hA + k), 3'b000});
                in_at[k] = cyc_no - 1; idx++;
            end
            if (fo) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL b2b_extra: result %h with nothing expected", obs_res);
                else begin
                    e = sb.pop_front();
                    if ({obs_res, obs_tag, obs_flg} !== e)
                        $display("FAIL b2b_data: got %h/%h/%b want %h/%h/%b", obs_res, obs_tag, obs_flg, e.res, e.tag, e.flg);
                    else n_pass++;
                end
                if (nout < 2) out_at[nout] = cyc_no - 1;
                nout++;
            end
        end
        n_checks++;
        if (nout != 2 || idx != 2) $display("FAIL b2b_count: got %0d outputs %0d inputs want 2/2", nout, idx);
        else n_pass++;
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (nout != 2 || idx != 2 || out_at[j] - in_at[j] != 3 || in_at[1] != in_at[0] + 1)
                $display("FAIL b2b_latency[%0d]: got in=%0d out=%0d want out=in+3, inputs consecutive", j, in_at[j], out_at[j]);
            else n_pass++;
        end
    endtask

    task automatic test_directed;
        localparam int N = 10;
        logic [15:0] av[N] = '{16'h3C01, 16'h3C01, 16'h7BFF, 16'h7C00, 16'h0400,
                               16'hBC00, 16'h7E00, 16'h8000, 16'hC000, 16'hFC01};
        logic [15:0] bv[N] = '{16'h3C01, 16'h3E00, 16'h4000, 16'h0000, 16'h3800,
                               16'h7C00, 16'h3C00, 16'h3C00, 16'hC000, 16'h4000};
        logic [15:0] rv[N] = '{16'h3C02, 16'h3E02, 16'h7C00, 16'h7E00, 16'h0000,
                               16'hFC00, 16'h7E00, 16'h8000, 16'h4400, 16'h7E00};
        logic [2:0]  fv[N] = '{3'b000, 3'b000, 3'b010, 3'b100, 3'b001,
                               3'b000, 3'b100, 3'b000, 3'b000, 3'b100};
        int   idx = 0, nout = 0, k, guard = 0;
        logic fi, fo;
        exp_t e;
        while ((idx < N || sb.size() > 0) && guard < 60) begin
            k = (idx < N) ? idx : 0;
            cyc(idx < N, av[k], bv[k], 4'(k), 1'b1, fi, fo);
            if (fi) begin sb.push_back('{rv[k], 4'(k), fv[k]}); idx++; end
            if (fo) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL vec_extra: result %h with nothing expected", obs_res);
                else begin
                    e = sb.pop_front();
                    if ({obs_res, obs_tag, obs_flg} !== e)
                        $display("FAIL vec[%0d]: got %h/%h/%b want %h/%h/%b", nout, obs_res, obs_tag, obs_flg, e.res, e.tag, e.flg);
                    else n_pass++;
                end
                nout++;
            end
            guard++;
        end
        n_checks++;
        if (nout != N) $display("FAIL vec_count: got %0d outputs want %0d", nout, N);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_backpressure;
        logic [15:0] bv[5] = '{16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600};
        int   idx = 0, nout = 0, k, guard = 0;
        logic fi, fo;
        exp_t e;
        for (int i = 0; i < 8; i++) begin
            k = (idx < 5) ? idx : 0;
            cyc(idx < 5, 16'h3C00, bv[k], 4'(k + 1), 1'b0, fi, fo);
            if (fi) begin sb.push_back('{bv[k], 4'(k + 1), 3'b000}); idx++; end
            if (obs_ov && sb.size() > 0) begin
                n_checks++;
                if ({obs_res, obs_tag, obs_flg} !== sb[0])
                    $display("FAIL bp_hold: got %h/%h/%b want %h/%h/%b", obs_res, obs_tag, obs_flg, sb[0].res, sb[0].tag, sb[0].flg);
                else n_pass++;
            end
        end
        n_checks++;
        if (idx != 3 || obs_ir !== 1'b0) $display("FAIL bp_stall: got accepted=%0d in_ready=%b want 3/0", idx, obs_ir);
        else n_pass++;
        while ((idx < 5 || sb.size() > 0) && guard < 30) begin
            k = (idx < 5) ? idx : 0;
            cyc(idx < 5, 16'h3C00, bv[k], 4'(k + 1), 1'b1, fi, fo);
            if (fi) begin sb.push_back('{bv[k], 4'(k + 1), 3'b000}); idx++; end
            if (fo) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL bp_extra: result %h with nothing expected", obs_res);
                else begin
                    e = sb.pop_front();
                    if ({obs_res, obs_tag, obs_flg} !== e)
                        $display("FAIL bp_drain[%0d]: got %h/%h/%b want %h/%h/%b", nout, obs_res, obs_tag, obs_flg, e.res, e.tag, e.flg);
                    else n_pass++;
                end
                nout++;
            end
            guard++;
        end
        repeat (3) begin
            cyc(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, fi, fo);
            if (fo) nout++;
        end
        n_checks++;
        if (nout != 5) $display("FAIL bp_count: got %0d outputs want 5", nout);
        else n_pass++;
        sb.delete();
    endtask

    task automatic test_mid_reset;
        int   nout = 0, guard = 0;
        logic fi, fo, done = 1'b0;
        exp_t e;
        cyc(1'b1, 16'h3C00, 16'h4000, 4'h1, 1'b0, fi, fo);
        cyc(1'b1, 16'h3C00, 16'h4200, 4'h2, 1'b0, fi, fo);
        cyc(1'b0, 16'h0, 16'h0, 4'h0, 1'b0, fi, fo);
        n_checks++;
        if (out_valid !== 1'b1) $display("FAIL mr_inflight: got out_valid=%b want 1", out_valid);
        else n_pass++;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || result !== 16'h0) $display("FAIL mr_async: got out_valid=%b result=%h want 0/0000", out_valid, result);
        else n_pass++;
        @(posedge clk_in); #1;
        rst_n = 1'b1;
        repeat (8) begin
            cyc(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, fi, fo);
            if (fo) nout++;
        end
        n_checks++;
        if (nout != 0) $display("FAIL mr_ghost: got %0d outputs after reset want 0", nout);
        else n_pass++;
        sb.push_back('{16'h3C00, 4'h7, 3'b000});
        cyc(1'b1, 16'h3C00, 16'h3C00, 4'h7, 1'b1, fi, fo);
        while (!done && guard < 10) begin
            cyc(1'b0, 16'h0, 16'h0, 4'h0, 1'b1, fi, fo);
            if (fo) begin
                done = 1'b1;
                e = sb.pop_front();
                n_checks++;
                if ({obs_res, obs_tag, obs_flg} !== e)
                    $display("FAIL mr_next: got %h/%h/%b want %h/%h/%b", obs_res, obs_tag, obs_flg, e.res, e.tag, e.flg);
                else n_pass++;
            end
            guard++;
        end
        if (!done) begin n_checks++; $display("FAIL mr_timeout: got no output want 3C00"); end
        sb.delete();
    endtask

    task automatic test_random;
        localparam int N = 10000;
        int          issued = 0, nout = 0, guard = 0;
        logic        fi, fo, v, ordy, s;
        logic [4:0]  ea, eb;
        logic [9:0]  fa, fb;
        logic [15:0] opa, opb;
        logic [3:0]  t;
        exp_t        e;
        ea = 5'($urandom_range(1, 30)); fa = 10'($urandom_range(0, 1023)); s = 1'($urandom_range(0, 1));
        opa = {s, ea, fa};
        eb = 5'($urandom_range(1, 30)); fb = 10'($urandom_range(0, 1023)); s = 1'($urandom_range(0, 1));
        opb = {s, eb, fb};
        t = 4'($urandom_range(0, 15));
        while ((issued < N || sb.size() > 0) && guard < 40000) begin
            v    = (issued < N) && ($urandom_range(0, 9) != 0);
            ordy = ($urandom_range(0, 3) != 0);
            cyc(v, opa, opb, t, ordy, fi, fo);
            if (fi) begin
                sb.push_back(model(opa, opb, t));
                issued++;
                ea = 5'($urandom_range(1, 30)); fa = 10'($urandom_range(0, 1023)); s = 1'($urandom_range(0, 1));
                opa = {s, ea, fa};
                eb = 5'($urandom_range(1, 30)); fb = 10'($urandom_range(0, 1023)); s = 1'($urandom_range(0, 1));
                opb = {s, eb, fb};
                t = 4'($urandom_range(0, 15));
            end
            if (fo) begin
                n_checks++;
                if (sb.size() == 0) $display("FAIL rnd_extra: result %h with nothing expected", obs_res);
                else begin
                    e = sb.pop_front();
                    if ({obs_res, obs_tag, obs_flg} !== e)
                        $display("FAIL rnd[%0d]: got %h/%h/%b want %h/%h/%b", nout, obs_res, obs_tag, obs_flg, e.res, e.tag, e.flg);
                    else n_pass++;
                end
                nout++;
            end
            guard++;
        end
        n_checks++;
        if (nout != N) $display("FAIL rnd_count: got %0d outputs want %0d", nout, N);
        else n_pass++;
        sb.delete();
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_directed();
        test_backpressure();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
